torus_link_port: RTL and testbench
==================================

Name: torus_link_port

Overview:
- Per-port link controller that sits between one router port and one PORT_SIZE slice of the torus connector.
- Drives the outgoing slice (data_i side of the connector) and consumes the incoming slice (data_o side).
- TX side: single-entry output register. RX side: FIFO that absorbs words from the neighbour node.
- Four instances per node, one for each of connector ports 0..3.

Parameters:
DATA_W, 37, payload width per link word
PORT_SIZE, DATA_W+2, connector slice width: payload plus valid plus ready
FIFO_DEPTH, 4, RX FIFO entries; power of two, at least 2
CNT_W, $clog2(FIFO_DEPTH+1), width of the RX occupancy count

Ports:
clk  input  1  single clock; all state updates on its rising edge
rst  input  1  asynchronous, active-high reset
link_i  input  PORT_SIZE  incoming slice from connector data_o
link_o  output  PORT_SIZE  outgoing slice to connector data_i
tx_data_i  input  DATA_W  word from the local router
tx_valid_i  input  1  local TX request
tx_ready_o  output  1  local TX accept
rx_data_o  output  DATA_W  head word of the RX FIFO
rx_valid_o  output  1  RX FIFO non-empty
rx_ready_i  input  1  local consumer pops the head word
rx_count_o  output  CNT_W  RX FIFO occupancy

Behaviour:
- Reset is asynchronous and active-high. One clock, clk.
- Slice layout, identical for link_i and link_o:
  - [DATA_W-1:0] = data
  - [DATA_W] = vld (sender holds a word)
  - [DATA_W+1] = rdy (this node's RX can accept a word from the peer)
- Link transfer happens in any cycle where the sender's vld=1 and the receiver's rdy=1. Both bits come from registers, so there is no combinational path across the connector.
- TX register (tx_full, tx_reg):
  - link_o data = tx_reg; link_o vld = tx_full.
  - link_accept = tx_full & link_i[DATA_W+1].
  - tx_ready_o = !tx_full | link_accept. This is pass-through, so a full register can be refilled in the same cycle it drains.
  - Local load = tx_valid_i & tx_ready_o: tx_reg <= tx_data_i, tx_full <= 1.
  - link_accept without a load: tx_full <= 0; tx_reg keeps its old value.
  - A word therefore appears on link_o one cycle after local acceptance.
- RX FIFO:
  - link_o rdy = (count < FIFO_DEPTH), computed from the registered count only.
  - push = link_i vld & link_o rdy. pop = rx_valid_o & rx_ready_i.
  - rx_valid_o = (count != 0). rx_data_o = mem[rd_ptr].
  - rx_count_o = count.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
  - Push and pop in the same cycle leave count unchanged and advance both pointers.
  - Full: rdy=0, so no push; a pop frees a slot, and rdy rises the next cycle.
  - Empty: no bypass; a pushed word is visible on rx_data_o one cycle after the link transfer.
  - pop with count=0 cannot occur, because rx_valid_o=0.
- Reset values:
  - tx_full=0, tx_reg=0, so link_o=0 except rdy=1.
  - count=0, wr_ptr=0, rd_ptr=0.
  - tx_ready_o=1, rx_valid_o=0, rx_data_o=mem[0] (memory contents are not reset; the value is don't-care).
- Reset mid-transfer: the word in tx_reg and all FIFO contents are discarded.
- A peer that samples rdy=1 during a cycle in which this node is in reset may see a transfer. That transfer is lost, which is acceptable because all nodes share the reset.
- End-to-end latency with no stalls: local TX accept to peer rx_valid_o = 2 cycles.

Decomposition:
- Shared package torus_pkg holds:
  - DATA_W, PORT_SIZE
  - field index constants VLD_BIT=DATA_W and RDY_BIT=DATA_W+1
  - port direction constants PORT_E=0, PORT_S=1, PORT_W=2, PORT_N=3, matching the connector's slot order
- One sub-module, link_rx_fifo, is natural: parameterised synchronous FIFO with push, pop, count, full and empty.
- The TX register stays inline in torus_link_port.

Test Plan:
1. Reset checks:
   - Assert rst mid-cycle, release.
   - Required: link_o = {1'b1, 1'b0, 37'h0}, tx_ready_o=1, rx_valid_o=0, rx_count_o=0, with no clock edge needed.
2. Back-to-back pair:
   - Two instances cross-connected (A.link_o->B.link_i and the reverse). Push 0x1_2345_6789 into A at cycle 0.
   - Required: A.link_o vld=1 at cycle 1; B.rx_valid_o=1 with rx_data_o=0x1_2345_6789 at cycle 2.
3. Backpressure:
   - B.rx_ready_i=0, A streams 6 words 1..6.
   - Required: B.rx_count_o saturates at 4 and B's rdy goes 0.
   - Required: A holds word 5 in tx_reg with tx_ready_o=0.
   - Release rx_ready_i: words 5 and 6 arrive in order with no loss or duplication.
4. Simultaneous push and pop:
   - At count=2, one link transfer plus one pop in the same cycle.
   - Required: count stays 2; the head advances to the next word.
5. Pointer wrap:
   - Stream 10 words 0x10..0x19 through FIFO_DEPTH=4 with rx_ready_i toggling every cycle.
   - Required: the output sequence is exactly 0x10..0x19.
6. Reset mid-operation:
   - Assert rst while tx_full=1 and count=3.
   - Required: count=0 and link_o vld=0 immediately; after release, a new word 0x7 is delivered normally.

Source files
------------

// File: rtl/torus_pkg.sv
// Shared torus link definitions: word width, connector slice layout and port slot order.
package torus_pkg;

    localparam int unsigned DATA_W    = 37;
    localparam int unsigned PORT_SIZE = DATA_W + 2;

    localparam int unsigned VLD_BIT = DATA_W;
    localparam int unsigned RDY_BIT = DATA_W + 1;

    localparam int unsigned PORT_E = 0;
    localparam int unsigned PORT_S = 1;
    localparam int unsigned PORT_W = 2;
    localparam int unsigned PORT_N = 3;

    // Packed view of one connector slice; bit order matches VLD_BIT/RDY_BIT.
    typedef struct packed {
        logic              rdy;
        logic              vld;
        logic [DATA_W-1:0] data;
    } link_slice_t;

endpackage

// File: rtl/link_rx_fifo.sv
// Synchronous FIFO absorbing words arriving from the neighbour node.
module link_rx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 37,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign count_o = count_q;
    assign rdata_o = mem[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/torus_link_port.sv
// Per-port torus link controller: single-entry TX register toward the connector,
// RX FIFO for words arriving from the neighbour.
module torus_link_port
    import torus_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PORT_SIZE-1:0] link_i,
    output logic [PORT_SIZE-1:0] link_o,
    input  logic [DATA_W-1:0]    tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic [DATA_W-1:0]    rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic [CNT_W-1:0]     rx_count_o
);

    link_slice_t       in_s, out_s;
    logic              tx_full_q;
    logic [DATA_W-1:0] tx_reg_q;
    logic              link_accept, tx_load;
    logic              rx_full, rx_empty, rx_rdy, rx_push, rx_pop;

    assign in_s = link_i;

    // Pass-through ready: a draining register can be refilled in the same cycle.
    assign link_accept = tx_full_q & in_s.rdy;
    assign tx_ready_o  = ~tx_full_q | link_accept;
    assign tx_load     = tx_valid_i & tx_ready_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_full_q <= 1'b0;
            tx_reg_q  <= '0;
        end else if (tx_load) begin
            tx_full_q <= 1'b1;
            tx_reg_q  <= tx_data_i;
        end else if (link_accept) begin
            tx_full_q <= 1'b0;
        end
    end

    // rdy depends only on the registered count, so nothing combinational crosses the link.
    assign rx_rdy     = ~rx_full;
    assign rx_push    = in_s.vld & rx_rdy;
    assign rx_valid_o = ~rx_empty;
    assign rx_pop     = rx_valid_o & rx_ready_i;

    link_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W),
        .CNT_W (CNT_W)
    ) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rx_push),
        .wdata_i (in_s.data),
        .pop_i   (rx_pop),
        .rdata_o (rx_data_o),
        .count_o (rx_count_o),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    always_comb begin
        out_s      = '0;
        out_s.data = tx_reg_q;
        out_s.vld  = tx_full_q;
        out_s.rdy  = rx_rdy;
    end

    assign link_o = out_s;

endmodule

// File: tb/tb_torus_link_port.sv
// Two cross-connected link ports (A transmits, B receives) driven with directed vectors.
module tb_torus_link_port;
    import torus_pkg::*;

    localparam int unsigned CNT_W = 3;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [PORT_SIZE-1:0] a_link_o, b_link_o;
    logic [DATA_W-1:0]    a_tx_data = '0, b_tx_data = '0;
    logic                 a_tx_valid = 1'b0, b_tx_valid = 1'b0;
    logic                 a_tx_ready, b_tx_ready;
    logic [DATA_W-1:0]    a_rx_data, b_rx_data;
    logic                 a_rx_valid, b_rx_valid;
    logic                 a_rx_ready = 1'b1, b_rx_ready = 1'b0;
    logic [CNT_W-1:0]     a_rx_count, b_rx_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    torus_link_port #(.FIFO_DEPTH(4), .CNT_W(CNT_W)) u_a (
        .clk        (clk),
        .rst        (rst),
        .link_i     (b_link_o),
        .link_o     (a_link_o),
        .tx_data_i  (a_tx_data),
        .tx_valid_i (a_tx_valid),
        .tx_ready_o (a_tx_ready),
        .rx_data_o  (a_rx_data),
        .rx_valid_o (a_rx_valid),
        .rx_ready_i (a_rx_ready),
        .rx_count_o (a_rx_count)
    );

    torus_link_port #(.FIFO_DEPTH(4), .CNT_W(CNT_W)) u_b (
        .clk        (clk),
        .rst        (rst),
        .link_i     (a_link_o),
        .link_o     (b_link_o),
        .tx_data_i  (b_tx_data),
        .tx_valid_i (b_tx_valid),
        .tx_ready_o (b_tx_ready),
        .rx_data_o  (b_rx_data),
        .rx_valid_o (b_rx_valid),
        .rx_ready_i (b_rx_ready),
        .rx_count_o (b_rx_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive tx_n words from A and expect rx_n words popped from B, in order.
    task automatic stream(input string tag, input logic [DATA_W-1:0] tx_first, input int tx_n,
                          input logic [DATA_W-1:0] rx_first, input int rx_n, input bit toggle);
        int                sent = 0;
        int                got  = 0;
        bit                acc, pop;
        logic [DATA_W-1:0] pd;
        a_tx_valid = (tx_n > 0);
        a_tx_data  = tx_first;
        for (int cyc = 0; cyc < 200 && got < rx_n; cyc++) begin
            b_rx_ready = toggle ? cyc[0] : 1'b1;
            acc = a_tx_valid && a_tx_ready;
            pop = b_rx_valid && b_rx_ready;
            pd  = b_rx_data;
            step();
            if (pop) begin
                check($sformatf("%s word%0d", tag, got), 64'(pd), 64'(rx_first + DATA_W'(got)));
                got++;
            end
            if (acc) begin
                sent++;
                if (sent < tx_n) a_tx_data = tx_first + DATA_W'(sent);
                else a_tx_valid = 1'b0;
            end
        end
        a_tx_valid = 1'b0;
        b_rx_ready = 1'b0;
        check({tag, " words received"}, 64'(got), 64'(rx_n));
        check({tag, " fifo drained"}, 64'(b_rx_count), 64'd0);
    endtask

    initial begin
        // 1. asynchronous reset, observed without a clock edge
        step();
        #3 rst = 1'b1;
        #1;
        check("rst a_link_o", 64'(a_link_o), 64'h40_0000_0000);
        check("rst a_tx_ready", 64'(a_tx_ready), 64'd1);
        check("rst b_rx_valid", 64'(b_rx_valid), 64'd0);
        check("rst b_rx_count", 64'(b_rx_count), 64'd0);
        #2 rst = 1'b0;
        step();

        // 2. single word latency A -> B
        a_tx_valid = 1'b1;
        a_tx_data  = 37'h1_2345_6789;
        step();
        a_tx_valid = 1'b0;
        check("b2b a vld", 64'(a_link_o[VLD_BIT]), 64'd1);
        check("b2b a data", 64'(a_link_o[DATA_W-1:0]), 64'h1_2345_6789);
        check("b2b b early", 64'(b_rx_valid), 64'd0);
        step();
        check("b2b b valid", 64'(b_rx_valid), 64'd1);
        check("b2b b data", 64'(b_rx_data), 64'h1_2345_6789);
        b_rx_ready = 1'b1;
        step();
        b_rx_ready = 1'b0;
        check("b2b popped", 64'(b_rx_count), 64'd0);

        // 3. backpressure: B stalled, A offers 1..6
        for (int w = 1; w <= 5; w++) begin
            a_tx_valid = 1'b1;
            a_tx_data  = DATA_W'(w);
            check($sformatf("bp accept%0d", w), 64'(a_tx_ready), 64'd1);
            step();
        end
        a_tx_data = 37'd6;
        check("bp b count", 64'(b_rx_count), 64'd4);
        check("bp b rdy", 64'(b_link_o[RDY_BIT]), 64'd0);
        check("bp a holds", 64'(a_link_o), {25'd0, 2'b11, 37'd5});
        check("bp a stalled", 64'(a_tx_ready), 64'd0);
        step();
        check("bp still full", 64'(b_rx_count), 64'd4);
        check("bp still stalled", 64'(a_tx_ready), 64'd0);
        stream("bp", 37'd6, 1, 37'd1, 6, 1'b0);

        // 4. simultaneous push and pop at count 2
        a_tx_valid = 1'b1;
        a_tx_data  = 37'h21;
        step();
        a_tx_data = 37'h22;
        step();
        a_tx_data = 37'h23;
        step();
        a_tx_valid = 1'b0;
        check("pp count before", 64'(b_rx_count), 64'd2);
        check("pp head before", 64'(b_rx_data), 64'h21);
        b_rx_ready = 1'b1;
        step();
        b_rx_ready = 1'b0;
        check("pp count after", 64'(b_rx_count), 64'd2);
        check("pp head after", 64'(b_rx_data), 64'h22);
        stream("pp drain", 37'd0, 0, 37'h22, 2, 1'b0);

        // 5. pointer wrap with a toggling consumer
        stream("wrap", 37'h10, 10, 37'h10, 10, 1'b1);

        // 6. reset while a word is held and the FIFO has 3 entries
        for (int w = 0; w < 4; w++) begin
            a_tx_valid = 1'b1;
            a_tx_data  = 37'h31 + DATA_W'(w);
            step();
        end
        a_tx_valid = 1'b0;
        check("mid count 3", 64'(b_rx_count), 64'd3);
        check("mid a vld", 64'(a_link_o[VLD_BIT]), 64'd1);
        #3 rst = 1'b1;
        #1;
        check("mid rst count", 64'(b_rx_count), 64'd0);
        check("mid rst a_link_o", 64'(a_link_o), 64'h40_0000_0000);
        check("mid rst b valid", 64'(b_rx_valid), 64'd0);
        #2 rst = 1'b0;
        step();
        stream("post rst", 37'h7, 1, 37'h7, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
